// File: rtl/int2flt_pkg.sv
// Shared types and widths for the sequential int16 -> half-float converter.
package int2flt_pkg;

  localparam int unsigned DATA_W   = 16;
  localparam int unsigned BYTE_W   = 8;
  localparam int unsigned EXP_W    = 5;
  localparam int unsigned MAN_W    = 10;
  localparam int unsigned BIAS     = 15;
  localparam int unsigned EXP_INIT = BIAS + DATA_W - 1;

  typedef enum logic [3:0] {
    IDLE,
    LD_LO,
    LD_HI,
    PREP,
    NORM,
    RND,
    WR_LO,
    WR_HI,
    DONE
  } state_t;

endpackage

// File: rtl/int2flt_seq_f16_round.sv
// Rounds a normalised 16-bit magnitude to a half-precision result.
module f16_round
  import int2flt_pkg::*;
(
  input  logic [DATA_W-1:0] i_mag,
  input  logic [EXP_W-1:0]  i_exp,
  input  logic              i_sign,
  input  logic              i_round_en,
  output logic [DATA_W-1:0] o_result_c
);

  localparam int unsigned SUM_W = MAN_W + 1;

  logic [MAN_W-1:0] w_mant;
  logic             w_guard;
  logic             w_sticky;
  logic             w_inc;
  logic [SUM_W-1:0] w_sum;
  logic [EXP_W-1:0] w_exp;
  logic             w_unused;

  // mag[15] is the implicit leading one and never reaches the encoding.
  assign w_unused = i_mag[DATA_W-1];

  always_comb begin
    w_mant     = i_mag[DATA_W-2 -: MAN_W];
    w_guard    = i_mag[DATA_W-2-MAN_W];
    w_sticky   = |i_mag[DATA_W-3-MAN_W:0];
    w_inc      = i_round_en && w_guard && (w_sticky || w_mant[0]);
    w_sum      = {1'b0, w_mant} + SUM_W'(w_inc);
    // A mantissa carry-out leaves the low bits at zero and bumps the exponent.
    w_exp      = i_exp + EXP_W'(w_sum[MAN_W]);
    o_result_c = {i_sign, w_exp, w_sum[MAN_W-1:0]};
  end

endmodule

// File: rtl/int2flt_seq.sv
// Sequential int16 -> half-float converter: loads from data memory, normalises
// one bit per clock, rounds, writes the result back and pulses done.
module int2flt_seq
  import int2flt_pkg::*;
#(
  parameter logic [7:0] ADDR_IN  = 8'd0,
  parameter logic [7:0] ADDR_OUT = 8'd2,
  parameter bit         ROUND_EN = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              done,
  output logic [BYTE_W-1:0] dm_addr,
  output logic [BYTE_W-1:0] dm_din,
  input  logic [BYTE_W-1:0] dm_dout,
  output logic              dm_we
);

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_start_q;
  logic [DATA_W-1:0]   r_int;
  logic                r_sign;
  logic [DATA_W-1:0]   r_mag;
  logic [EXP_W-1:0]    r_exp;
  logic [DATA_W-1:0]   r_result;
  logic                r_done;
  logic                r_we;
  logic [BYTE_W-1:0]   r_addr;
  logic [BYTE_W-1:0]   r_din;

  logic [DATA_W-1:0]   w_mag_abs;
  logic [DATA_W-1:0]   w_round_c;
  logic [DATA_W-1:0]   w_res_c;
  logic                w_done_nxt;
  logic                w_we_nxt;
  logic [BYTE_W-1:0]   w_addr_nxt;
  logic [BYTE_W-1:0]   w_din_nxt;

  // Two's-complement magnitude; 0x8000 stays 0x8000 as an unsigned value.
  assign w_mag_abs = r_int[DATA_W-1] ? DATA_W'(~r_int + DATA_W'(1)) : r_int;

  f16_round u_round (
    .i_mag      (r_mag),
    .i_exp      (r_exp),
    .i_sign     (r_sign),
    .i_round_en (ROUND_EN),
    .o_result_c (w_round_c)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next state, plus output values registered for the state being entered.
  always_comb begin
    w_state_nxt = r_state;
    w_addr_nxt  = '0;
    w_din_nxt   = '0;
    w_we_nxt    = 1'b0;
    w_done_nxt  = 1'b0;
    w_res_c     = r_result;
    if (r_state == RND)       w_res_c = w_round_c;
    else if (r_state == PREP) w_res_c = '0;

    case (r_state)
      IDLE:    if (r_start_q && !start) w_state_nxt = LD_LO;
      LD_LO:   w_state_nxt = LD_HI;
      LD_HI:   w_state_nxt = PREP;
      PREP:    w_state_nxt = (w_mag_abs == '0) ? WR_LO : NORM;
      NORM:    if (r_mag[DATA_W-1]) w_state_nxt = RND;
      RND:     w_state_nxt = WR_LO;
      WR_LO:   w_state_nxt = WR_HI;
      WR_HI:   w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase

    case (w_state_nxt)
      LD_LO: w_addr_nxt = ADDR_IN;
      LD_HI: w_addr_nxt = ADDR_IN + 8'd1;
      WR_LO: begin
        w_addr_nxt = ADDR_OUT;
        w_din_nxt  = w_res_c[BYTE_W-1:0];
        w_we_nxt   = 1'b1;
      end
      WR_HI: begin
        w_addr_nxt = ADDR_OUT + 8'd1;
        w_din_nxt  = w_res_c[DATA_W-1:BYTE_W];
        w_we_nxt   = 1'b1;
      end
      DONE:    w_done_nxt = 1'b1;
      default: w_addr_nxt = '0;
    endcase
  end

  // Datapath: operand load, normalising shifter and result capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_start_q <= 1'b0;
      r_int     <= '0;
      r_sign    <= 1'b0;
      r_mag     <= '0;
      r_exp     <= '0;
      r_result  <= '0;
      r_done    <= 1'b0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_din     <= '0;
    end else begin
      r_start_q <= start;
      r_result  <= w_res_c;
      r_done    <= w_done_nxt;
      r_we      <= w_we_nxt;
      r_addr    <= w_addr_nxt;
      r_din     <= w_din_nxt;
      case (r_state)
        LD_LO: r_int[BYTE_W-1:0]      <= dm_dout;
        LD_HI: r_int[DATA_W-1:BYTE_W] <= dm_dout;
        PREP: begin
          r_sign <= r_int[DATA_W-1];
          r_mag  <= w_mag_abs;
          r_exp  <= EXP_W'(EXP_INIT);
        end
        // One shift per cycle; the cycle that sees mag[15] set only exits.
        NORM: if (!r_mag[DATA_W-1]) begin
          r_mag <= r_mag << 1;
          r_exp <= r_exp - EXP_W'(1);
        end
        default: r_int <= r_int;
      endcase
    end
  end

  assign done    = r_done;
  assign dm_we   = r_we;
  assign dm_addr = r_addr;
  assign dm_din  = r_din;

endmodule

// File: tb/tb_int2flt_seq.sv
// Scoreboard bench for int2flt_seq: a rounding and a truncating instance run in lockstep.
module tb_int2flt_seq;

  typedef struct {
    logic [15:0] res;
    int          lat;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       done_r, done_t;
  logic       we_r, we_t;
  logic [7:0] addr_r, addr_t, din_r, din_t, dout_r, dout_t;
  logic [7:0] mem_r [256];
  logic [7:0] mem_t [256];

  exp_t q_r[$];
  exp_t q_t[$];
  int   cyc = 0;
  int   launch_cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  int   n_done = 0;

  logic [15:0] v_in  [7] = '{16'h0001, 16'h0000, 16'h7FFF, 16'h8000, 16'hFFFF, 16'h0801, 16'h0803};
  logic [15:0] v_rnd [7] = '{16'h3C00, 16'h0000, 16'h7800, 16'hF800, 16'hBC00, 16'h6800, 16'h6802};
  logic [15:0] v_trn [7] = '{16'h3C00, 16'h0000, 16'h77FF, 16'hF800, 16'hBC00, 16'h6800, 16'h6801};
  int          v_lat [7] = '{22, 5, -1, -1, -1, -1, -1};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  int2flt_seq #(.ADDR_IN(8'd0), .ADDR_OUT(8'd2), .ROUND_EN(1'b1)) u_rnd (
    .clk(clk), .reset(reset), .start(start), .done(done_r),
    .dm_addr(addr_r), .dm_din(din_r), .dm_dout(dout_r), .dm_we(we_r)
  );

  int2flt_seq #(.ADDR_IN(8'd0), .ADDR_OUT(8'd2), .ROUND_EN(1'b0)) u_trn (
    .clk(clk), .reset(reset), .start(start), .done(done_t),
    .dm_addr(addr_t), .dm_din(din_t), .dm_dout(dout_t), .dm_we(we_t)
  );

  assign dout_r = mem_r[addr_r];
  assign dout_t = mem_t[addr_t];
  always @(posedge clk) if (we_r) mem_r[addr_r] <= din_r;
  always @(posedge clk) if (we_t) mem_t[addr_t] <= din_t;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", name, got, exp);
  endtask

  always @(negedge clk) if (done_r) begin
    exp_t e;
    n_done++;
    if (q_r.size() == 0) chk("rnd_unexpected_done", 32'(q_r.size()), 32'd1);
    else begin
      e = q_r.pop_front();
      chk("rnd_result", 32'({mem_r[3], mem_r[2]}), 32'(e.res));
      if (e.lat >= 0) chk("rnd_latency", 32'(cyc - launch_cyc), 32'(e.lat));
    end
  end

  always @(negedge clk) if (done_t) begin
    exp_t e;
    n_done++;
    if (q_t.size() == 0) chk("trn_unexpected_done", 32'(q_t.size()), 32'd1);
    else begin
      e = q_t.pop_front();
      chk("trn_result", 32'({mem_t[3], mem_t[2]}), 32'(e.res));
      if (e.lat >= 0) chk("trn_latency", 32'(cyc - launch_cyc), 32'(e.lat));
    end
  end

  task automatic preload(input logic [15:0] val, input logic [7:0] fill);
    @(negedge clk);
    mem_r[0] <= val[7:0];
    mem_r[1] <= val[15:8];
    mem_r[2] <= fill;
    mem_r[3] <= fill;
    mem_t[0] <= val[7:0];
    mem_t[1] <= val[15:8];
    mem_t[2] <= fill;
    mem_t[3] <= fill;
  endtask

  // A high-then-low pulse on start; LD_LO begins at the next rising edge.
  task automatic launch();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    launch_cyc = cyc + 1;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40; i++) begin
      if (q_r.size() == 0 && q_t.size() == 0) break;
      @(negedge clk);
    end
    if (q_r.size() != 0 || q_t.size() != 0) begin
      chk("done_timeout", 32'(q_r.size() + q_t.size()), 32'd0);
      q_r.delete();
      q_t.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic run_vec(input logic [15:0] val, input logic [15:0] er,
                         input logic [15:0] et, input int lat);
    exp_t e;
    preload(val, 8'hEE);
    e.lat = lat;
    e.res = er;
    q_r.push_back(e);
    e.res = et;
    q_t.push_back(e);
    launch();
    wait_idle();
  endtask

  initial begin
    int done_snap;
    reset = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_rnd", 32'({done_r, we_r, addr_r, din_r}), 32'd0);
    chk("reset_trn", 32'({done_t, we_t, addr_t, din_t}), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 7; i++) run_vec(v_in[i], v_rnd[i], v_trn[i], v_lat[i]);

    // Abort a long conversion while it is normalising.
    preload(16'h0001, 8'hA5);
    done_snap = n_done;
    launch();
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (30) @(negedge clk);
    chk("abort_mem_rnd", 32'({mem_r[3], mem_r[2]}), 32'h0000A5A5);
    chk("abort_mem_trn", 32'({mem_t[3], mem_t[2]}), 32'h0000A5A5);
    chk("abort_no_done", 32'(n_done), 32'(done_snap));

    run_vec(16'h0005, 16'h4500, 16'h4500, -1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
